canvas_streamer: RTL and testbench

//  Consumes the 28x28 drawing canvas (16-bit intensity per block, indexed [x][y], 0..2047) produced by the

---
 rtl/canvas_streamer.sv | 78 +++++++
 tb/tb_canvas_streamer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/canvas_streamer.sv
// canvas_streamer: snapshots the 28x28 canvas on Start and streams it row-major, one clamped pixel per handshake.
module canvas_streamer #(
    parameter int DIM     = 28,
    parameter int WIDTH   = 16,
    parameter int MAX_VAL = 2047
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 Start,
    input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   canvas,
    input  logic                                 pix_ready,
    output logic                                 pix_valid,
    output logic [WIDTH-1:0]                     pix_data,
    output logic [9:0]                           pix_index,
    output logic                                 pix_last,
    output logic                                 Busy,
    output logic                                 Done,
    output logic                                 Empty
);
    localparam int CW = $clog2(DIM);
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    state_t state;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0] snap;
    logic [CW-1:0] x, y;
    logic [WIDTH-1:0] raw;
    logic at_end;
    assign raw       = snap[x][y];
    assign pix_data  = raw > MAXV ? MAXV : raw;
    assign pix_index = 10'(y) * 10'(DIM) + 10'(x);
    assign at_end    = x == LAST && y == LAST;
    assign pix_last  = pix_valid & at_end;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            pix_valid <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Empty     <= 1'b0;
            snap      <= '0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    snap      <= canvas;
                    Empty     <= canvas == '0;
                    x         <= '0;
                    y         <= '0;
                    pix_valid <= 1'b1;
                    Busy      <= 1'b1;
                    state     <= STREAM;
                end
                STREAM: if (pix_ready) begin
                    if (at_end) begin
                        x         <= '0;
                        y         <= '0;
                        pix_valid <= 1'b0;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        state     <= DONE;
                    end else if (x == LAST) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_canvas_streamer.sv
// tb_canvas_streamer: directed checks of snapshot, row-major order, clamping, stalls, abort and back-to-back streams.
module tb_canvas_streamer;
    logic Clk = 0, Reset = 1, Start = 0, pix_ready = 0;
    logic [27:0][27:0][15:0] canvas = '0;
    logic pix_valid, pix_last, Busy, Done, Empty;
    logic [15:0] pix_data;
    logic [9:0] pix_index;
    int vectors = 0, miscompares = 0;
    logic [15:0] expv [784];

    canvas_streamer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .canvas(canvas), .pix_ready(pix_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_index(pix_index), .pix_last(pix_last),
        .Busy(Busy), .Done(Done), .Empty(Empty)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected stream: clamped canvas in row-major order, captured at Start time.
    task automatic build_exp();
        for (int n = 0; n < 784; n++)
            expv[n] = canvas[n % 28][n / 28] > 16'd2047 ? 16'd2047 : canvas[n % 28][n / 28];
    endtask

    task automatic run_stream(input bit rnd, input bit exp_empty, input bit poke, input bit hold);
        int n = 0;
        int cyc = 0;
        while (n < 784 && cyc < 5000) begin
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke) begin
                Start = (cyc % 7 == 3);
                canvas = {784{16'd1500}};
            end
            chk("valid", pix_valid, 1);
            chk("busy", Busy, 1);
            chk("done_mid", Done, 0);
            chk("data", pix_data, expv[n]);
            chk("index", pix_index, n);
            chk("last", pix_last, n == 783);
            chk("empty", Empty, exp_empty);
            if (pix_ready) n++;
            cyc++;
            tick();
        end
        chk("handshakes", n, 784);
        if (!rnd) chk("valid_cycles", cyc, 784);
        if (!hold) Start = 0;
        pix_ready = 0;
        chk("done_pulse", Done, 1);
        chk("valid_done", pix_valid, 0);
        chk("busy_done", Busy, 0);
        tick();
        chk("done_one_cycle", Done, 0);
        chk("valid_idle", pix_valid, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", pix_valid, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_empty", Empty, 0);
        chk("rst_last", pix_last, 0);
        chk("rst_index", pix_index, 0);
        Reset = 0;
        tick();
        chk("idle_valid", pix_valid, 0);
        // T1: empty canvas
        build_exp();
        Start = 1;
        tick();
        Start = 0;
        run_stream(0, 1, 0, 0);
        // T2: ramp with a clamped corner
        for (int x = 0; x < 28; x++)
            for (int y = 0; y < 28; y++)
                canvas[x][y] = 16'(x + 100 * y);
        canvas[27][27] = 16'd4000;
        build_exp();
        chk("t2_corner", expv[783], 2047);
        Start = 1;
        tick();
        Start = 0;
        run_stream(0, 0, 0, 0);
        // T3: random stalls
        Start = 1;
        tick();
        Start = 0;
        run_stream(1, 0, 0, 0);
        // T4: canvas rewritten and Start pulsed during the stream
        Start = 1;
        tick();
        Start = 0;
        run_stream(1, 0, 1, 0);
        tick();
        chk("t4_no_restart", pix_valid, 0);
        chk("t4_no_busy", Busy, 0);
        // T5: reset mid-stream
        for (int x = 0; x < 28; x++)
            for (int y = 0; y < 28; y++)
                canvas[x][y] = 16'(x + 100 * y);
        build_exp();
        Start = 1;
        tick();
        Start = 0;
        pix_ready = 1;
        for (int i = 0; i < 300; i++) tick();
        chk("t5_beat300", pix_index, 300);
        Reset = 1;
        tick();
        Reset = 0;
        pix_ready = 0;
        chk("t5_valid", pix_valid, 0);
        chk("t5_done", Done, 0);
        chk("t5_busy", Busy, 0);
        chk("t5_data_cleared", pix_data, 0);
        tick();
        chk("t5_done_after", Done, 0);
        Start = 1;
        tick();
        Start = 0;
        run_stream(0, 0, 0, 0);
        // T6: Start held high
        Start = 1;
        tick();
        run_stream(0, 0, 0, 1);
        tick();
        chk("t6_restart_valid", pix_valid, 1);
        chk("t6_restart_index", pix_index, 0);
        Start = 0;
        run_stream(0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
